tfhe_pu_c2h_packetizer: RTL and testbench
=========================================

Name: tfhe_pu_c2h_packetizer

Overview:
- Card-to-host (C2H) direction of the PCIe path: takes result words from the TFHE processing unit and frames them into AXI4-Stream packets for the PCIe DMA C2H channel.
- Each packet is one header beat followed by WORDS_PER_CT payload beats.
- Sits between the processing-unit result port and the DMA C2H stream inside the block design.
- Counterpart of the host-to-card (H2C) ingest path.

Parameters:
- DATA_W, 256, stream and result word width in bits; multiple of 64.
- WORDS_PER_CT, 64, payload beats per packet; range 1..65535.
- FIFO_DEPTH, 16, result FIFO entries; power of two, at least 2.
- TAG_W, 16, ciphertext tag width; at most 16.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous reset, active-high.
- i_start  in  1  one-cycle pulse; begin one packet.
- i_tag  in  TAG_W  tag sampled with i_start.
- s_valid  in  1  result word valid.
- s_data  in  DATA_W  result word.
- s_ready  out  1  FIFO can accept a word.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tkeep  out  DATA_W/8  byte enables; always all ones.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  DMA ready.
- m_axis_tlast  out  1  last beat of packet.
- o_busy  out  1  packet in progress.
- o_start_drop  out  1  one-cycle pulse: i_start ignored.
- o_pkt_count  out  32  completed packets; wraps.

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, o_busy=0, o_start_drop=0, o_pkt_count=0, sequence number=0, FIFO empty, state IDLE, s_ready=0 during the reset cycle.
- Result FIFO (depth FIFO_DEPTH):
  - s_ready = !full, registered.
  - A write occurs when s_valid && s_ready, in any state.
  - Simultaneous read and write when full or empty is legal; occupancy stays consistent.
- FSM states: IDLE, HEADER, PAYLOAD.
- IDLE:
  - i_start latches i_tag, sets o_busy, moves to HEADER.
  - The header beat is presented with m_axis_tvalid=1 on the next cycle (one-cycle latency).
- HEADER beat layout:
  - [15:0]=16'hC2E0 (magic)
  - [31:16]=tag, zero-extended
  - [47:32]=WORDS_PER_CT
  - [63:48]=16-bit sequence number
  - upper bits zero
  - On handshake (tvalid && tready): move to PAYLOAD, clear beat counter.
- PAYLOAD:
  - Output register is loaded from the FIFO head when the FIFO is non-empty and the output is empty or being accepted. Full-throughput skid behaviour: one beat per cycle with FIFO non-empty and tready high.
  - FIFO empty: m_axis_tvalid=0 (bubble). A valid beat is never dropped.
  - tlast=1 on beat index WORDS_PER_CT-1. Beat counter is 16-bit, compared against WORDS_PER_CT-1.
  - On the tlast handshake: o_pkt_count+1, sequence number+1 (wraps 0xFFFF->0), o_busy=0, back to IDLE.
  - tvalid may assert in the same cycle as IDLE is re-entered only if a new i_start arrived the cycle before.
- AXI-Stream rules: once tvalid=1, tdata/tlast hold stable until the handshake; tvalid never deasserts without a handshake.
- i_start in HEADER or PAYLOAD: ignored, o_start_drop=1 for one cycle.
- i_start in the same cycle as the final tlast handshake: also dropped. The packet boundary is strict.
- Surplus FIFO words beyond WORDS_PER_CT remain queued for the next packet.
- Reset mid-packet:
  - tvalid=0 the cycle after rst is sampled.
  - FIFO flushed, counters cleared, no partial tlast emitted.
  - The DMA side treats the truncated packet as aborted.

Optional Feature:
- Macro: C2H_CHECKSUM_EN.
- Defined:
  - Adds a TRAILER state after PAYLOAD.
  - The trailer beat carries the DATA_W-bit XOR of all payload beats of the packet.
  - tlast moves from the last payload beat to the trailer.
  - Header [79:64]=16'h0001 flags the checksum.
  - Packet length is WORDS_PER_CT+2 beats.
  - The checksum accumulator clears on the header handshake.
- Undefined: no TRAILER state, header [79:64]=0, packet length is WORDS_PER_CT+1 beats.

Decomposition:
- Package tfhe_pu_c2h_pkg:
  - magic constant 16'hC2E0
  - header field bit offsets
  - flag constant
  - FSM state enum (IDLE, HEADER, PAYLOAD, TRAILER)
- Sub-module tfhe_pu_sync_fifo:
  - parameterised width/depth
  - registered full/empty
  - first-word-fall-through read
  - instantiated once for the result FIFO

Test Plan (bench overrides WORDS_PER_CT=4, FIFO_DEPTH=8):
- Basic packet: preload 4 words 0x1..0x4, pulse i_start with tag 0x00AB, tready=1 -> header next cycle with [15:0]=C2E0, [31:16]=00AB, [47:32]=4, seq=0; then 0x1..0x4 on consecutive cycles, tlast on 0x4; o_pkt_count=1.
- Backpressure: random tready, 30% low -> tdata/tlast stable while stalled; output order 0x1..0x4 unchanged; no duplicate beats.
- Starvation: i_start with FIFO empty; feed one word every 3 cycles -> tvalid bubbles; exactly 4 payload beats; tlast on the 4th.
- Busy start: second i_start mid-payload -> o_start_drop pulses once; the packet completes normally; the next header shows seq=1 after a fresh start.
- Reset mid-packet: rst after 2 payload beats -> tvalid=0 next cycle; s_ready=0 during reset, 1 after; next packet header seq=0, o_pkt_count=0.
- C2H_CHECKSUM_EN: payload 0xF0, 0x0F, 0xFF, 0x01 -> trailer tdata=0x01 with tlast; header [79:64]=1; 6 beats total.

Source files
------------

// File: rtl/tfhe_pu_c2h_pkg.sv
// Shared constants and types for the C2H packetizer: header layout, flags and FSM states.
package tfhe_pu_c2h_pkg;

  localparam logic [15:0] C2H_MAGIC         = 16'hC2E0;
  localparam logic [15:0] C2H_FLAG_CHECKSUM = 16'h0001;

  localparam int HDR_MAGIC_LSB = 0;
  localparam int HDR_TAG_LSB   = 16;
  localparam int HDR_LEN_LSB   = 32;
  localparam int HDR_SEQ_LSB   = 48;
  localparam int HDR_FLAG_LSB  = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TRAILER = 2'd3
  } c2h_state_e;

endpackage

// File: rtl/tfhe_pu_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
module tfhe_pu_sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1'b1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             full_q;
  logic             empty_q;
  logic             wr_s;
  logic             rd_s;

  assign wr_s       = wr_valid_i && !full_q;
  assign rd_s       = rd_en_i && !empty_q;
  assign wr_ready_o = !full_q;
  assign empty_o    = empty_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  // Occupancy next-state; a read and a write together leave it unchanged.
  always_comb begin
    case ({wr_s, rd_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers and flags; full holds high through reset so no write is taken then.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_q <= rd_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == CNT_MAX);
      empty_q  <= (cnt_d == '0);
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/tfhe_pu_c2h_packetizer.sv
// Frames processing-unit result words into header + payload AXI4-Stream packets for the DMA C2H channel.
// Optional checksum trailer beat when C2H_CHECKSUM_EN is defined.
module tfhe_pu_c2h_packetizer
  import tfhe_pu_c2h_pkg::*;
#(
  parameter int DATA_W       = 256,
  parameter int WORDS_PER_CT = 64,
  parameter int FIFO_DEPTH   = 16,
  parameter int TAG_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [TAG_W-1:0]    i_tag,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  output logic                s_ready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                o_busy,
  output logic                o_start_drop,
  output logic [31:0]         o_pkt_count
);

`ifdef C2H_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam logic [15:0] PKT_WORDS = 16'(WORDS_PER_CT);
  localparam logic [15:0] LAST_BEAT = 16'(WORDS_PER_CT - 1);

  c2h_state_e        state_q, state_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;
  logic [15:0]       beat_q, beat_d;
  logic [15:0]       seq_q, seq_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;
`ifdef C2H_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif
  logic [DATA_W-1:0] hdr_s;
  logic [DATA_W-1:0] fifo_data_s;
  logic              fifo_empty_s;
  logic              fifo_rd_s;
  logic              hs_s;

  tfhe_pu_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (s_valid),
    .wr_data_i  (s_data),
    .wr_ready_o (s_ready),
    .rd_en_i    (fifo_rd_s),
    .rd_data_o  (fifo_data_s),
    .empty_o    (fifo_empty_s)
  );

  assign hs_s          = tvalid_q && m_axis_tready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = '1;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign o_busy        = busy_q;
  assign o_start_drop  = drop_q;
  assign o_pkt_count   = pkt_cnt_q;

  // Header beat assembled from the live tag and current sequence number.
  always_comb begin
    hdr_s = '0;
    hdr_s[HDR_MAGIC_LSB +: 16] = C2H_MAGIC;
    hdr_s[HDR_TAG_LSB   +: 16] = 16'(i_tag);
    hdr_s[HDR_LEN_LSB   +: 16] = PKT_WORDS;
    hdr_s[HDR_SEQ_LSB   +: 16] = seq_q;
`ifdef C2H_CHECKSUM_EN
    hdr_s[HDR_FLAG_LSB  +: 16] = C2H_FLAG_CHECKSUM;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; beat_q == PKT_WORDS means the last payload beat is in the output register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = i_start ? ST_HEADER : ST_IDLE;
      ST_HEADER:  state_d = hs_s ? ST_PAYLOAD : ST_HEADER;
      ST_PAYLOAD: begin
        if (hs_s && (beat_q == PKT_WORDS)) begin
          state_d = CSUM_EN ? ST_TRAILER : ST_IDLE;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_TRAILER: state_d = hs_s ? ST_IDLE : ST_TRAILER;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and skid-style output register loading.
  always_comb begin
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    busy_d    = busy_q;
    beat_d    = beat_q;
    seq_d     = seq_q;
    pkt_cnt_d = pkt_cnt_q;
    fifo_rd_s = 1'b0;
    drop_d    = i_start && (state_q != ST_IDLE);
`ifdef C2H_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = hdr_s;
          busy_d   = 1'b1;
        end else begin
          tvalid_d = 1'b0;
        end
      end
      ST_HEADER: begin
        beat_d = 16'd0;
        if (hs_s) begin
`ifdef C2H_CHECKSUM_EN
          csum_d = '0;
`endif
          if (!fifo_empty_s) begin
            tvalid_d  = 1'b1;
            tdata_d   = fifo_data_s;
            tlast_d   = !CSUM_EN && (LAST_BEAT == 16'd0);
            beat_d    = 16'd1;
            fifo_rd_s = 1'b1;
          end else begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
        end else begin
          tvalid_d = tvalid_q;
        end
      end
      ST_PAYLOAD: begin
`ifdef C2H_CHECKSUM_EN
        csum_d = hs_s ? (csum_q ^ tdata_q) : csum_q;
`endif
        if (hs_s && (beat_q == PKT_WORDS)) begin
`ifdef C2H_CHECKSUM_EN
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          tdata_d  = csum_q ^ tdata_q;
`else
          tvalid_d  = 1'b0;
          tlast_d   = 1'b0;
          busy_d    = 1'b0;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          seq_d     = seq_q + 16'd1;
`endif
        end else if ((!tvalid_q || hs_s) && !fifo_empty_s) begin
          tvalid_d  = 1'b1;
          tdata_d   = fifo_data_s;
          tlast_d   = !CSUM_EN && (beat_q == LAST_BEAT);
          beat_d    = beat_q + 16'd1;
          fifo_rd_s = 1'b1;
        end else if (hs_s) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end else begin
          tvalid_d = tvalid_q;
        end
      end
      ST_TRAILER: begin
        if (hs_s) begin
          tvalid_d  = 1'b0;
          tlast_d   = 1'b0;
          busy_d    = 1'b0;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          seq_d     = seq_q + 16'd1;
        end else begin
          tvalid_d = tvalid_q;
        end
      end
      default: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
      beat_q    <= 16'd0;
      seq_q     <= 16'd0;
      pkt_cnt_q <= 32'd0;
`ifdef C2H_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
      beat_q    <= beat_d;
      seq_q     <= seq_d;
      pkt_cnt_q <= pkt_cnt_d;
`ifdef C2H_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_tfhe_pu_c2h_packetizer.sv
// Scoreboard bench for tfhe_pu_c2h_packetizer (honours C2H_CHECKSUM_EN when defined).
module tb_tfhe_pu_c2h_packetizer;

  localparam int DW  = 256;
  localparam int WPC = 4;
  localparam int FD  = 8;
  localparam int TW  = 16;
`ifdef C2H_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_start = 1'b0;
  logic [TW-1:0]   i_tag = '0;
  logic            s_valid = 1'b0;
  logic [DW-1:0]   s_data = '0;
  logic            s_ready;
  logic [DW-1:0]   m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b0;
  logic            m_axis_tlast;
  logic            o_busy;
  logic            o_start_drop;
  logic [31:0]     o_pkt_count;

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int pkts_seen = 0;
  int pay_seen = 0;
  int bubbles = 0;
  int hdr_cyc = 0;
  int last_cyc = 0;
  int start_cyc = 0;
  bit in_pkt = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] xsum = '0;
  logic [15:0]   exp_seq = 16'd0;
  logic [DW-1:0] hdr_q[$];
  logic [DW-1:0] word_q[$];

  tfhe_pu_c2h_packetizer #(
    .DATA_W(DW), .WORDS_PER_CT(WPC), .FIFO_DEPTH(FD), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_tag(i_tag),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .o_busy(o_busy),
    .o_start_drop(o_start_drop), .o_pkt_count(o_pkt_count)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_hdr(input logic [15:0] tag, input logic [15:0] seq);
    logic [DW-1:0] h;
    h = '0;
    h[15:0]  = 16'hC2E0;
    h[31:16] = tag;
    h[47:32] = 16'(WPC);
    h[63:48] = seq;
    if (CSUM != 0) h[79:64] = 16'h0001;
    return h;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    bit took;
    took = 1'b0;
    s_data  = w;
    s_valid = 1'b1;
    for (int i = 0; i < 50 && !took; i++) begin
      @(negedge clk);
      took = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check_val("write_accepted", took, 1);
    if (took) word_q.push_back(w);
  endtask

  task automatic start(input logic [15:0] tag, input bit accept);
    i_tag     = tag;
    i_start   = 1'b1;
    start_cyc = cyc;
    if (accept) begin
      hdr_q.push_back(mk_hdr(tag, exp_seq));
      exp_seq++;
    end
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input bit rnd);
    for (int i = 0; i < 300 && pkts_seen < target; i++) begin
      if (rnd) m_axis_tready = ($urandom_range(0, 9) >= 3);
      tick(1);
    end
    m_axis_tready = 1'b1;
    check_val("pkt_complete", pkts_seen, target);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    hdr_q.delete();
    word_q.delete();
    exp_seq = 16'd0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Output monitor: stability rules plus scoreboard compare on every handshake.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_pkt = 1'b0;
      pay_seen = 0;
      prev_stall = 1'b0;
    end else begin
      if (o_busy && !m_axis_tvalid) bubbles++;
      if (prev_stall) begin
        check_val("hold_valid", m_axis_tvalid, 1);
        check_val("hold_data", m_axis_tdata, prev_data);
        check_val("hold_last", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (!in_pkt) begin
          check_val("hdr_avail", hdr_q.size() != 0, 1);
          if (hdr_q.size() != 0) check_val("hdr_data", m_axis_tdata, hdr_q.pop_front());
          check_val("hdr_last", m_axis_tlast, 0);
          in_pkt = 1'b1; pay_seen = 0; xsum = '0; hdr_cyc = cyc;
        end else if (pay_seen < WPC) begin
          check_val("word_avail", word_q.size() != 0, 1);
          if (word_q.size() != 0) check_val("pay_data", m_axis_tdata, word_q.pop_front());
          xsum = xsum ^ m_axis_tdata;
          pay_seen++;
          check_val("pay_last", m_axis_tlast, (pay_seen == WPC) && (CSUM == 0));
          if (pay_seen == WPC && CSUM == 0) begin
            in_pkt = 1'b0; pkts_seen++; last_cyc = cyc;
          end
        end else begin
          check_val("trl_data", m_axis_tdata, xsum);
          check_val("trl_last", m_axis_tlast, 1);
          in_pkt = 1'b0; pkts_seen++; last_cyc = cyc;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  initial begin
    tick(1);
    check_val("rst_sready", s_ready, 0);
    check_val("rst_tvalid", m_axis_tvalid, 0);
    check_val("rst_tlast", m_axis_tlast, 0);
    check_val("rst_tdata", m_axis_tdata, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_drop", o_start_drop, 0);
    check_val("rst_pktcnt", o_pkt_count, 0);
    check_val("tkeep", m_axis_tkeep, 32'hFFFF_FFFF);
    tick(1);
    rst = 1'b0;
    tick(1);
    check_val("post_rst_sready", s_ready, 1);
    m_axis_tready = 1'b1;

    // basic packet, full throughput
    for (int i = 1; i <= 4; i++) write_word(DW'(i));
    start(16'h00AB, 1'b1);
    wait_pkts(1, 1'b0);
    check_val("hdr_latency", hdr_cyc, start_cyc + 1);
    check_val("burst_len", last_cyc - hdr_cyc, WPC + CSUM);
    check_val("pktcnt_1", o_pkt_count, 1);

    // random backpressure
    for (int i = 1; i <= 4; i++) write_word(DW'(i));
    start(16'h0012, 1'b1);
    wait_pkts(2, 1'b1);
    check_val("pktcnt_2", o_pkt_count, 2);

    // starvation: start on empty FIFO, trickle words in
    bubbles = 0;
    start(16'h0033, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      write_word(DW'(32'h30 + i));
      tick(2);
    end
    wait_pkts(3, 1'b0);
    check_val("bubbles_seen", bubbles > 0, 1);

    // checksum vector
    write_word(DW'(8'hF0));
    write_word(DW'(8'h0F));
    write_word(DW'(8'hFF));
    write_word(DW'(8'h01));
    start(16'h000C, 1'b1);
    wait_pkts(4, 1'b0);
    check_val("csum_burst_len", last_cyc - hdr_cyc, WPC + CSUM);

    // start while busy is dropped
    reset_dut();
    for (int i = 1; i <= 4; i++) write_word(DW'(32'h40 + i));
    start(16'h0044, 1'b1);
    for (int i = 0; i < 50 && !(in_pkt && pay_seen >= 1); i++) tick(1);
    check_val("mid_payload", in_pkt && pay_seen >= 1, 1);
    start(16'h0055, 1'b0);
    check_val("drop_pulse", o_start_drop, 1);
    tick(1);
    check_val("drop_clear", o_start_drop, 0);
    wait_pkts(5, 1'b0);
    start(16'h0066, 1'b1);
    check_val("drop_idle", o_start_drop, 0);
    for (int i = 1; i <= 4; i++) write_word(DW'(32'h60 + i));
    wait_pkts(6, 1'b0);
    check_val("pktcnt_after_drop", o_pkt_count, 2);

    // reset in the middle of a packet with a beat pending
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 4; i++) write_word(DW'(32'h50 + i));
    start(16'h0077, 1'b1);
    m_axis_tready = 1'b1;
    tick(3);
    m_axis_tready = 1'b0;
    check_val("pre_rst_beats", pay_seen, 2);
    check_val("pre_rst_valid", m_axis_tvalid, 1);
    rst = 1'b1;
    hdr_q.delete();
    word_q.delete();
    exp_seq = 16'd0;
    tick(1);
    check_val("midrst_tvalid", m_axis_tvalid, 0);
    check_val("midrst_sready", s_ready, 0);
    check_val("midrst_busy", o_busy, 0);
    rst = 1'b0;
    tick(1);
    check_val("midrst_sready_after", s_ready, 1);
    check_val("midrst_pktcnt", o_pkt_count, 0);
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 4; i++) write_word(DW'(32'h70 + i));
    start(16'h0078, 1'b1);
    wait_pkts(7, 1'b0);
    check_val("pktcnt_after_rst", o_pkt_count, 1);
    check_val("queues_drained", hdr_q.size() + word_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
